// File: rtl/rv_alu_decoder_if.sv
`default_nettype none
// ============================================================================
// Module      : rv_alu_decoder_if
// Description : Decode-to-execute bundle for the RV32I ALU control decoder.
//               The master drives the decode-stage fields and receives the
//               registered ALU select. The slave is the decoder itself.
//   in_valid    - decode-stage fields are valid this cycle
//   opb5        - opcode bit 5 (1 = R-type, 0 = I-type ALU)
//   funct3      - instruction funct3 field
//   funct7b5    - instruction funct7 bit 5
//   alu_op      - class from main decoder
//   alu_control - registered ALU operation select
//   out_valid   - registered copy of in_valid
//   illegal     - registered unsupported-encoding flag
// Revision    : 1.0 - initial release
// ============================================================================
interface rv_alu_decoder_if;
    logic       in_valid;
    logic       opb5;
    logic [2:0] funct3;
    logic       funct7b5;
    logic [1:0] alu_op;
    logic [2:0] alu_control;
    logic       out_valid;
    logic       illegal;

    modport master (
        output in_valid, opb5, funct3, funct7b5, alu_op,
        input  alu_control, out_valid, illegal
    );

    modport slave (
        input  in_valid, opb5, funct3, funct7b5, alu_op,
        output alu_control, out_valid, illegal
    );
endinterface
`default_nettype wire

// File: rtl/rv_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : rv_alu_decoder
// Description : Second-level ALU control decoder for the RV32I pipeline.
//               Maps alu_op/funct3/funct7[5]/opcode[5] to a 3-bit ALU select
//               through one register stage (1-cycle latency, no stall).
//               Unsupported encodings raise 'illegal', qualified by in_valid.
// Ports       : clk   - system clock, rising edge
//               reset - synchronous active-high reset
//               bus   - decode/execute bundle (slave side)
// Revision    : 1.0 - initial release
// ============================================================================
module rv_alu_decoder (
    input  wire logic          clk,
    input  wire logic          reset,
    rv_alu_decoder_if.slave    bus
);
    localparam logic [2:0] c_ALU_ADD = 3'b000;
    localparam logic [2:0] c_ALU_SUB = 3'b001;
    localparam logic [2:0] c_ALU_AND = 3'b010;
    localparam logic [2:0] c_ALU_OR  = 3'b011;
    localparam logic [2:0] c_ALU_SLT = 3'b101;

    logic [2:0] w_ctrl;
    logic       w_bad;
    logic       w_valid;

    logic [2:0] r_ctrl;
    logic       r_valid;
    logic       r_illegal;

    // Case items are matched exactly, so any X/Z on a decoded bit falls into
    // a default branch and is reported as an unsupported encoding.
    always_comb begin
        w_ctrl = c_ALU_ADD;
        w_bad  = 1'b0;
        case (bus.alu_op)
            2'b00: w_ctrl = c_ALU_ADD;
            2'b01: w_ctrl = c_ALU_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000: begin
                        // Only R-type with funct7[5] set is a subtract;
                        // I-type addi ignores funct7[5].
                        case ({bus.opb5, bus.funct7b5})
                            2'b11:               w_ctrl = c_ALU_SUB;
                            2'b00, 2'b01, 2'b10: w_ctrl = c_ALU_ADD;
                            default:             w_bad  = 1'b1;
                        endcase
                    end
                    3'b010:  w_ctrl = c_ALU_SLT;
                    3'b110:  w_ctrl = c_ALU_OR;
                    3'b111:  w_ctrl = c_ALU_AND;
                    default: w_bad  = 1'b1;
                endcase
            end
            default: w_bad = 1'b1;
        endcase
        if (w_bad) begin
            w_ctrl = c_ALU_ADD;
        end
    end

    // An unknown in_valid is treated as not valid so out_valid never goes X.
    always_comb begin
        w_valid = 1'b0;
        case (bus.in_valid)
            1'b1:    w_valid = 1'b1;
            default: w_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctrl    <= c_ALU_ADD;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_ctrl    <= w_ctrl;
            r_valid   <= w_valid;
            r_illegal <= w_bad & w_valid;
        end
    end

    assign bus.alu_control = r_ctrl;
    assign bus.out_valid   = r_valid;
    assign bus.illegal     = r_illegal;
endmodule
`default_nettype wire

// File: tb/tb_rv_alu_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv_alu_decoder
// Description : Self-checking bench for rv_alu_decoder. Directed steps plus a
//               randomized stream, each checked one cycle after sampling
//               against a table-driven reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv_alu_decoder;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    rv_alu_decoder_if bus ();

    rv_alu_decoder dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Result of each R/I funct3 under alu_op=10; -1 marks unsupported,
    // -2 marks the add/sub split resolved by opb5 & funct7b5.
    int f3_tab [8] = '{-2, -1, 5, -1, -1, -1, 3, 2};

    logic [2:0] exp_ctrl;
    logic       exp_valid;
    logic       exp_ill;

    task automatic model(input logic v, input logic ob5, input logic [2:0] f3,
                         input logic f7, input logic [1:0] op);
        int  res;
        bit  bad;
        res = 0;
        bad = 0;
        if (reset === 1'b1) begin
            exp_ctrl = 3'd0; exp_valid = 1'b0; exp_ill = 1'b0;
            return;
        end
        if ($isunknown(op)) bad = 1;
        else if (op == 2'd0) res = 0;
        else if (op == 2'd1) res = 1;
        else if (op == 2'd3) bad = 1;
        else if ($isunknown(f3)) bad = 1;
        else begin
            res = f3_tab[f3];
            if (res == -1) bad = 1;
            else if (res == -2) begin
                if ($isunknown({ob5, f7})) bad = 1;
                else res = (ob5 && f7) ? 1 : 0;
            end
        end
        if (bad) res = 0;
        exp_ctrl  = 3'(res);
        exp_valid = (v === 1'b1);
        exp_ill   = exp_valid && bad;
    endtask

    task automatic step(input logic v, input logic ob5, input logic [2:0] f3,
                        input logic f7, input logic [1:0] op, input string tag);
        bus.in_valid = v;
        bus.opb5     = ob5;
        bus.funct3   = f3;
        bus.funct7b5 = f7;
        bus.alu_op   = op;
        model(v, ob5, f3, f7, op);
        @(posedge clk);
        #1;
        checks++;
        assert (bus.alu_control === exp_ctrl) else begin
            failures++;
            $error("FAIL %s alu_control got=%b exp=%b", tag, bus.alu_control, exp_ctrl);
        end
        checks++;
        assert (bus.out_valid === exp_valid) else begin
            failures++;
            $error("FAIL %s out_valid got=%b exp=%b", tag, bus.out_valid, exp_valid);
        end
        checks++;
        assert (bus.illegal === exp_ill) else begin
            failures++;
            $error("FAIL %s illegal got=%b exp=%b", tag, bus.illegal, exp_ill);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;

        // Reset held for two cycles with a live ori in flight.
        step(1'b1, 1'b0, 3'b110, 1'b0, 2'b10, "rst_hold0");
        step(1'b1, 1'b0, 3'b110, 1'b0, 2'b10, "rst_hold1");
        reset = 1'b0;
        step(1'b1, 1'b0, 3'b110, 1'b0, 2'b10, "rst_release");

        // Fixed classes with random funct fields.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), 2'b00, "class_add");
            step(1'b1, 1'($urandom), 3'($urandom), 1'($urandom), 2'b01, "class_sub");
        end

        // Add/sub split.
        step(1'b1, 1'b1, 3'b000, 1'b1, 2'b10, "sub_r");
        step(1'b1, 1'b0, 3'b000, 1'b0, 2'b10, "addi");
        step(1'b1, 1'b0, 3'b000, 1'b1, 2'b10, "addi_f7");
        step(1'b1, 1'b1, 3'b000, 1'b0, 2'b10, "add_r");

        // Logic / compare.
        step(1'b1, 1'b1, 3'b010, 1'b0, 2'b10, "slt");
        step(1'b1, 1'b0, 3'b110, 1'b0, 2'b10, "ori");
        step(1'b1, 1'b1, 3'b111, 1'b0, 2'b10, "and");

        // Unsupported encodings, valid then not valid.
        for (int pass = 0; pass < 2; pass++) begin
            logic v;
            v = (pass == 0);
            step(v, 1'b1, 3'b001, 1'b0, 2'b10, "ill_f3_001");
            step(v, 1'b1, 3'b011, 1'b0, 2'b10, "ill_f3_011");
            step(v, 1'b0, 3'b100, 1'b0, 2'b10, "ill_f3_100");
            step(v, 1'b0, 3'b101, 1'b1, 2'b10, "ill_f3_101");
            step(v, 1'b1, 3'b111, 1'b0, 2'b11, "ill_op11");
            step(v, 1'b1, 3'bxxx, 1'b0, 2'b10, "ill_f3_x");
        end

        // Mid-stream reset, then first valid one cycle after release.
        step(1'b1, 1'b1, 3'b111, 1'b0, 2'b10, "pre_rst");
        reset = 1'b1;
        step(1'b1, 1'b0, 3'b010, 1'b0, 2'b10, "mid_rst");
        reset = 1'b0;
        step(1'b1, 1'b0, 3'b010, 1'b0, 2'b10, "post_rst");

        // Back-to-back stream, then a longer randomized stream.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'($urandom), 3'($urandom), 1'($urandom),
                 2'($urandom_range(0, 2)), "b2b");
        end
        for (int i = 0; i < 200; i++) begin
            step(1'($urandom), 1'($urandom), 3'($urandom), 1'($urandom),
                 2'($urandom), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/rv_alu_decoder.md
Name: rv_alu_decoder

Overview:
- Second-level control decoder for the RV32I pipeline.
- Maps the main decoder's 2-bit alu_op, plus instruction fields funct3, funct7[5] and opcode[5], to the 3-bit ALU operation select.
- Output is registered: one pipeline stage between decode and execute.
- Unsupported encodings are flagged so the hazard/exception logic can squash the instruction.

Parameters:
- None. All widths are fixed by the ISA subset.

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  decode-stage fields below are valid this cycle
- opb5  in  1  opcode bit 5 (1 = R-type, 0 = I-type ALU)
- funct3  in  3  instruction funct3 field
- funct7b5  in  1  instruction funct7 bit 5
- alu_op  in  2  class from main decoder (00 add, 01 sub, 10 funct-decoded, 11 reserved)
- alu_control  out  3  registered ALU select (000 add, 001 sub, 010 and, 011 or, 101 slt)
- out_valid  out  1  registered copy of in_valid
- illegal  out  1  registered flag: unsupported encoding in this slot

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, reset).
- Reset: on a rising clk edge with reset=1, alu_control=000, out_valid=0 and illegal=0. Reset overrides all inputs.
- Latency: exactly 1 cycle. Inputs sampled at edge N appear on the outputs after edge N. No stall or handshake; a new decode is accepted every cycle.
- Combinational next-value decode, then one register stage:
  - alu_op=00 -> 000 (add; used by loads, stores, address calculation).
  - alu_op=01 -> 001 (sub; used by branch compare).
  - alu_op=10 with funct3=000:
    - opb5=1 and funct7b5=1 -> 001 (sub).
    - Otherwise -> 000 (add/addi). funct7b5 is ignored for I-type (opb5=0).
  - alu_op=10 with funct3=010 -> 101 (slt/slti).
  - alu_op=10 with funct3=110 -> 011 (or/ori).
  - alu_op=10 with funct3=111 -> 010 (and/andi).
  - alu_op=10 with any other funct3 (001, 011, 100, 101) -> 000, illegal_next=1.
  - alu_op=11 -> 000, illegal_next=1.
- Any X/Z on the decoded input bits is treated as an unsupported encoding: alu_control=000, illegal=1. The output must never carry X after reset.
- When in_valid=0:
  - alu_control still updates from the decode (don't-care for consumers).
  - illegal is forced to 0.
  - out_valid=0.
- The illegal flag is registered alongside alu_control. It is qualified by in_valid and never asserted while out_valid=0.
- Reset asserted mid-stream: the next edge clears all outputs; the first valid after reset deasserts is output one cycle later.

Test Plan:
- Reset: hold reset=1 for 2 cycles with alu_op=10, funct3=110, in_valid=1 -> alu_control=000, out_valid=0, illegal=0. Release reset -> next cycle alu_control=011, out_valid=1.
- Fixed classes: alu_op=00 -> 000; alu_op=01 -> 001, each one cycle after sampling. funct fields are random and must be ignored.
- Add/sub split with alu_op=10, funct3=000, one cycle after each:
  - opb5=1, funct7b5=1 -> 001.
  - opb5=0, funct7b5=0 -> 000.
  - opb5=0, funct7b5=1 -> 000.
  - opb5=1, funct7b5=0 -> 000.
- Logic/compare with alu_op=10 -> illegal=0 throughout:
  - funct3=010 -> 101.
  - funct3=110 -> 011.
  - funct3=111 -> 010.
- Unsupported encodings with in_valid=1 -> alu_control=000, illegal=1:
  - alu_op=10 with funct3=001, 011, 100 or 101.
  - alu_op=11.
  - funct3 driven to X.
  - Repeat with in_valid=0 -> illegal=0.
- Back-to-back stream: change the encoding every cycle for 8 cycles -> each output matches the previous cycle's input, with no bubbles or dropped entries.
